// File: rtl/serial_byte_loader_pkg.sv
// Shared types and sizing helpers for the serial byte loader and its accumulator.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STORE = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int CNT_W = $clog2(DEFAULT_DATA_WIDTH);

    // Counter width for a modulus, never narrower than one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/serial_byte_loader_shift_accumulator.sv
// Shift register plus bit counter; exposes the word including the bit being shifted in.
module shift_accumulator
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  shift,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] shifted_word,
    output logic                  done
);

    localparam int CW = cnt_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted_word = {sreg_q[DATA_WIDTH-2:0], bit_in};
        end else begin : g_lsb_first
            assign shifted_word = {bit_in, sreg_q[DATA_WIDTH-1:1]};
        end
    endgenerate

    // done flags that the bit now being offered is the last of the frame.
    assign done = (cnt_q == CW'(DATA_WIDTH - 1));

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clr) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (shift) begin
            sreg_d = shifted_word;
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_byte_loader.sv
// Assembles bit-serial frames into a byte and presents it to a transparent latch
// with a held store window, framing-error pulses and a stored-byte counter.
module serial_byte_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int STORE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  serial_in,
    input  logic                  bit_valid,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  store,
    output logic                  busy,
    output logic                  frame_error,
    output logic [7:0]            byte_count
);

    localparam int TW = cnt_width(STORE_CYCLES);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  store_q, store_d;
    logic                  busy_q, busy_d;
    logic                  frame_error_q, frame_error_d;
    logic [7:0]            byte_count_q, byte_count_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic                  acc_clr;
    logic                  acc_shift;
    logic [DATA_WIDTH-1:0] acc_word;
    logic                  acc_done;

    shift_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_acc (
        .clk          (clk),
        .reset        (reset),
        .clr          (acc_clr),
        .shift        (acc_shift),
        .bit_in       (serial_in),
        .shifted_word (acc_word),
        .done         (acc_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            data_q        <= '0;
            store_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
            byte_count_q  <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            store_q       <= store_d;
            busy_q        <= busy_d;
            frame_error_q <= frame_error_d;
            byte_count_q  <= byte_count_d;
            timer_q       <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_start) state_d = SHIFT;
            end
            SHIFT: begin
                if (abort)                        state_d = IDLE;
                else if (frame_start)             state_d = SHIFT;
                else if (bit_valid && acc_done)   state_d = STORE;
            end
            STORE: begin
                if (timer_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d        = data_q;
        store_d       = store_q;
        timer_d       = timer_q;
        frame_error_d = 1'b0;
        byte_count_d  = byte_count_q;
        acc_clr       = 1'b0;
        acc_shift     = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start)    acc_clr = 1'b1;
                else if (bit_valid) frame_error_d = 1'b1;
            end
            SHIFT: begin
                // abort wins over everything and leaves data untouched.
                if (abort) begin
                    acc_clr = 1'b0;
                end else if (frame_start) begin
                    frame_error_d = 1'b1;
                    acc_clr       = 1'b1;
                end else if (bit_valid) begin
                    acc_shift = 1'b1;
                    if (acc_done) begin
                        data_d       = acc_word;
                        store_d      = 1'b1;
                        timer_d      = TW'(STORE_CYCLES - 1);
                        byte_count_d = byte_count_q + 8'd1;
                    end
                end
            end
            STORE: begin
                if (bit_valid || frame_start) frame_error_d = 1'b1;
                if (timer_q == '0) store_d = 1'b0;
                else               timer_d = timer_q - TW'(1);
            end
            default: begin
                store_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign data        = data_q;
    assign store       = store_q;
    assign busy        = busy_q;
    assign frame_error = frame_error_q;
    assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench for serial_byte_loader: MSB-first unit plus an LSB-first unit sharing stimulus.
module tb_serial_byte_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       serial_in;
    logic       bit_valid;
    logic       abort;
    logic [7:0] data, data_l;
    logic       store, store_l;
    logic       busy, busy_l;
    logic       frame_error, frame_error_l;
    logic [7:0] byte_count, byte_count_l;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int store_hi = 0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_store = 1'b0;

    serial_byte_loader #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .STORE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .serial_in(serial_in),
        .bit_valid(bit_valid), .abort(abort), .data(data), .store(store), .busy(busy),
        .frame_error(frame_error), .byte_count(byte_count)
    );

    serial_byte_loader #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .STORE_CYCLES(2)) dut_lsb (
        .clk(clk), .reset(reset), .frame_start(frame_start), .serial_in(serial_in),
        .bit_valid(bit_valid), .abort(abort), .data(data_l), .store(store_l), .busy(busy_l),
        .frame_error(frame_error_l), .byte_count(byte_count_l)
    );

    always #5 clk = ~clk;

    // Data must hold steady across every cycle of a store window.
    always @(negedge clk) begin
        if (frame_error) err_pulses++;
        if (store) store_hi++;
        if (store && prev_store) begin
            checks++;
            if (data !== prev_data) begin
                errors++;
                $display("FAIL data_stable: data=%h was %h while store high", data, prev_data);
            end
        end
        prev_store = store;
        prev_data  = data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        serial_in = b;
        tick();
        bit_valid = 1'b0;
        serial_in = 1'b0;
    endtask

    // Sends the byte MSB first on the wire.
    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        $display("frame 0x%02h sent, data=%02h store=%0b count=%0d", b, data, store, byte_count);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({data, store, busy, frame_error, byte_count} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: data=%h store=%b busy=%b ferr=%b count=%0d, want all 0",
                     data, store, busy, frame_error, byte_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int e0 = err_pulses;
        do_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: busy=%b want 1", busy); end
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        send_bit(0); send_bit(1); send_bit(0);
        checks++;
        if (store !== 1'b0) begin errors++; $display("FAIL basic_early_store: store=%b want 0", store); end
        send_bit(1);
        $display("frame A5 sent, data=%02h lsb_data=%02h", data, data_l);
        checks++;
        if (store !== 1'b1 || data !== 8'hA5 || byte_count !== 8'd1) begin
            errors++;
            $display("FAIL basic_store1: store=%b data=%h count=%0d want 1 A5 1", store, data, byte_count);
        end
        checks++;
        if (data_l !== 8'hA5) begin errors++; $display("FAIL lsb_palindrome: data=%h want A5", data_l); end
        tick();
        checks++;
        if (store !== 1'b1) begin errors++; $display("FAIL basic_store2: store=%b want 1", store); end
        tick();
        checks++;
        if (store !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_store_end: store=%b busy=%b want 0 0", store, busy);
        end
        checks++;
        if (err_pulses != e0) begin errors++; $display("FAIL basic_no_err: pulses=%0d want 0", err_pulses - e0); end
    endtask

    task automatic test_lsb_first();
        do_start();
        send_bit(1);
        for (int i = 0; i < 7; i++) send_bit(0);
        $display("frame 1,0x7 sent, msb data=%02h lsb data=%02h", data, data_l);
        checks++;
        if (data_l !== 8'h01) begin errors++; $display("FAIL lsb_data: data=%h want 01", data_l); end
        checks++;
        if (data !== 8'h80) begin errors++; $display("FAIL msb_data: data=%h want 80", data); end
        // A stray bit inside the store window is an error but does not disturb the window.
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        checks++;
        if (frame_error !== 1'b1 || store !== 1'b1 || data !== 8'h80) begin
            errors++;
            $display("FAIL store_stray_bit: ferr=%b store=%b data=%h want 1 1 80", frame_error, store, data);
        end
        tick();
        checks++;
        if (store !== 1'b0 || byte_count !== 8'd2) begin
            errors++;
            $display("FAIL lsb_end: store=%b count=%0d want 0 2", store, byte_count);
        end
    endtask

    task automatic test_restart();
        int e0 = err_pulses;
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1);
        do_start();
        checks++;
        if (frame_error !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_err: ferr=%b busy=%b want 1 1", frame_error, busy);
        end
        send_byte(8'h3C);
        checks++;
        if (data !== 8'h3C || store !== 1'b1 || byte_count !== 8'd3) begin
            errors++;
            $display("FAIL restart_data: data=%h store=%b count=%0d want 3C 1 3", data, store, byte_count);
        end
        tick();
        tick();
        checks++;
        if (err_pulses - e0 != 1) begin errors++; $display("FAIL restart_pulses: got %0d want 1", err_pulses - e0); end
    endtask

    task automatic test_abort();
        int e0 = err_pulses;
        int s0 = store_hi;
        do_start();
        for (int i = 0; i < 5; i++) send_bit(1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("abort after 5 bits, busy=%b data=%02h", busy, data);
        checks++;
        if (busy !== 1'b0 || data !== 8'h3C) begin
            errors++;
            $display("FAIL abort_state: busy=%b data=%h want 0 3C", busy, data);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (store_hi != s0 || err_pulses != e0 || byte_count !== 8'd3) begin
            errors++;
            $display("FAIL abort_quiet: store_cycles=%0d err=%0d count=%0d want 0 0 3",
                     store_hi - s0, err_pulses - e0, byte_count);
        end
    endtask

    task automatic test_reset_in_store();
        do_start();
        send_byte(8'h55);
        checks++;
        if (store !== 1'b1) begin errors++; $display("FAIL rst_store_pre: store=%b want 1", store); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (store !== 1'b0 || data !== 8'h00 || byte_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_store: store=%b data=%h count=%0d busy=%b want 0 00 0 0",
                     store, data, byte_count, busy);
        end
        tick();
        bit_valid = 1'b1;
        serial_in = 1'b1;
        tick();
        bit_valid = 1'b0;
        serial_in = 1'b0;
        $display("bit in IDLE, ferr=%b busy=%b", frame_error, busy);
        checks++;
        if (frame_error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_bit_err: ferr=%b busy=%b want 1 0", frame_error, busy);
        end
        tick();
        checks++;
        if (frame_error !== 1'b0) begin errors++; $display("FAIL idle_err_width: ferr=%b want 0", frame_error); end
    endtask

    task automatic test_back_to_back();
        int e0 = err_pulses;
        int s0 = store_hi;
        for (int f = 0; f < 256; f++) begin
            do_start();
            send_byte(8'hFF);
            checks++;
            if (store !== 1'b1 || data !== 8'hFF || byte_count !== 8'((f + 1) % 256)) begin
                errors++;
                $display("FAIL b2b_frame%0d: store=%b data=%h count=%0d want 1 FF %0d",
                         f, store, data, byte_count, (f + 1) % 256);
            end
            tick();
            tick();
        end
        checks++;
        if (byte_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wrap: count=%0d busy=%b want 0 0", byte_count, busy);
        end
        checks++;
        if (store_hi - s0 != 512 || err_pulses != e0) begin
            errors++;
            $display("FAIL b2b_totals: store_cycles=%0d err=%0d want 512 0", store_hi - s0, err_pulses - e0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        serial_in   = 1'b0;
        bit_valid   = 1'b0;
        abort       = 1'b0;
        test_reset();
        test_basic();
        test_lsb_first();
        test_restart();
        test_abort();
        test_reset_in_store();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_byte_loader.md
Name: serial_byte_loader

Overview:
Upstream feeder for the byte-wide D-latch memory stage. Assembles a byte from a bit-serial stream, one bit per accepted strobe, then drives the latch's `data` bus and `store` enable. Data is held constant before, during and after the `store` window, so the transparent latch never captures a partial byte. Also reports framing errors and counts stored bytes for the board LEDs.

Parameters:
DATA_WIDTH, 8, bits per frame; must equal the latch data width.
MSB_FIRST, 1, 1 = first received bit lands in data[DATA_WIDTH-1]; 0 = first bit lands in data[0].
STORE_CYCLES, 2, number of clock cycles `store` is held high per byte (>=1).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
frame_start  input  1  single-cycle pulse; begins a new frame.
serial_in  input  1  serial data bit, sampled when bit_valid=1.
bit_valid  input  1  single-cycle strobe; qualifies serial_in.
abort  input  1  discards the frame in progress.
data  output  DATA_WIDTH  assembled byte, registered; feeds the latch data input.
store  output  1  registered latch enable; high for exactly STORE_CYCLES cycles per completed frame.
busy  output  1  high in SHIFT or STORE.
frame_error  output  1  one-cycle pulse on a protocol violation.
byte_count  output  8  number of bytes stored, modulo 256.

Behaviour:
- Reset (sync, active-high) clears all outputs and state.
  - data=0, store=0, busy=0, frame_error=0, byte_count=0.
  - Internal shift register = 0, bit counter = 0, state = IDLE.
  - Reset takes priority over every other input.
  - A reset during STORE drops `store` on the next edge; the byte is not counted.
- State IDLE:
  - frame_start=1 -> SHIFT. Shift register and bit counter are cleared.
  - bit_valid=1 without frame_start -> stay in IDLE, pulse frame_error, ignore the bit.
- State SHIFT:
  - Each cycle with bit_valid=1 shifts serial_in into the shift register and increments the bit counter.
  - MSB_FIRST=1: shift left, new bit enters at LSB. MSB_FIRST=0: shift right, new bit enters at MSB.
  - On the bit that completes the frame (counter == DATA_WIDTH-1 and bit_valid=1), on the same edge:
    - the completed word (including that bit) loads into `data`;
    - `store` goes high, byte_count increments;
    - state -> STORE.
  - Bit-to-store latency: `store` is high on the cycle after the edge that samples the last bit.
  - frame_start=1 in SHIFT -> pulse frame_error and restart. Counter and shift register clear, state stays SHIFT. A bit_valid in that same cycle is discarded.
  - abort=1 -> IDLE, no error pulse. `data` keeps its previous value. abort outranks frame_start and bit_valid.
- State STORE:
  - `store` stays high for STORE_CYCLES cycles total, then drops and state -> IDLE.
  - `data` does not change while `store` is high, nor afterwards until the next completed frame. The latch keeps seeing stable data.
  - bit_valid or frame_start in STORE -> frame_error pulse, input ignored.
  - abort in STORE is ignored; the store window always completes.
- busy = (state != IDLE), registered.
- byte_count wraps 255 -> 0.
- Outputs are registered only; there are no combinational paths from inputs to outputs.
- Back-to-back frames: frame_start is accepted on the first IDLE cycle after STORE. The minimum frame period is DATA_WIDTH + STORE_CYCLES + 1 cycles.

Decomposition:
- Shared package `loader_pkg`: state enum (IDLE, SHIFT, STORE), DATA_WIDTH default, counter width localparam $clog2(DATA_WIDTH).
- One natural sub-module, `shift_accumulator`: shift register plus bit counter, with inputs clr/shift/bit_in and a done flag. The FSM, store-window timer and counters stay in the top.

Test Plan:
- Reset, then frame_start, then bits 1,0,1,0,0,1,0,1 (MSB_FIRST=1) -> data=0xA5, store high for 2 cycles starting on the cycle after the 8th bit, byte_count=1, frame_error never pulses.
- Same bit sequence with MSB_FIRST=0 -> data=0xA5 reversed = 0xA5 (palindrome check). Then send 1,0,0,0,0,0,0,0 -> data=0x01.
- Send 4 bits, then frame_start, then a full 0x3C frame -> one frame_error pulse at the restart, data=0x3C, byte_count increments by exactly 1.
- Send 5 bits, then abort -> state IDLE, data unchanged from the prior byte, store never asserts, no frame_error.
- Assert reset in the 1st cycle of STORE -> next cycle store=0, data=0, byte_count=0. A bit_valid while IDLE -> frame_error pulses exactly 1 cycle.
- Send 256 back-to-back frames of 0xFF at the minimum period -> byte_count wraps to 0. Data never changes while store=1 (checked by assertion every cycle).
